l3_mem_responder: RTL and testbench

L3_MEM_RESPONDER -- requirements
Module: l3_mem_responder

---
 rtl/l3_mem_responder.sv | 173 +++++++++++++++++
 tb/tb_l3_mem_responder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l3_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : l3_mem_responder
//  Purpose  : L3 line-fill responder: request FIFO with dedup, programmable
//             response latency and a non-reset 128B-line backing store.
//  Revision : 1.0 - initial release
// ============================================================================
module l3_mem_responder #(
    parameter int LINES  = 256,
    parameter int QDEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    lat_cfg,
    input  logic          mem_req,
    input  logic [47:0]   mem_addr,
    output logic [1023:0] mem_rdata,
    output logic          mem_valid,
    input  logic          wb_valid,
    input  logic [47:0]   wb_addr,
    input  logic [1023:0] wb_wdata,
    output logic [15:0]   req_drop_cnt,
    output logic          busy
);
    localparam int c_IDX_W = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int c_PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int c_CNT_W = $clog2(QDEPTH + 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [40:0]         r_fifo_line [QDEPTH];
    logic [QDEPTH-1:0]   r_fifo_vld;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [40:0]         r_svc_line;
    logic [3:0]          r_lat_cnt;
    logic [1:0]          r_last_cnt;
    logic                r_mem_valid;
    logic [1023:0]       r_mem_rdata;
    logic [15:0]         r_drop_cnt;
    logic [1023:0]       r_store [LINES];

    logic [40:0]         w_req_line;
    logic                w_fifo_hit;
    logic                w_discard;
    logic                w_pop;
    logic                w_respond;
    logic                w_accept;
    logic                w_drop;
    logic [c_IDX_W-1:0]  w_rd_idx;
    logic [c_IDX_W-1:0]  w_wb_idx;
    logic [1023:0]       w_rd_data;
    logic                w_unused;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(QDEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign w_req_line = mem_addr[47:7];
    assign w_rd_idx   = r_svc_line[c_IDX_W-1:0];
    assign w_wb_idx   = wb_addr[7 +: c_IDX_W];
    assign w_unused   = ^{wb_addr, mem_addr[6:0]};

    always_comb begin
        w_fifo_hit = 1'b0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (r_fifo_vld[i] && (r_fifo_line[i] == w_req_line)) begin
                w_fifo_hit = 1'b1;
            end
        end
    end

    // The service line stays put until the next pop, so it also serves as the
    // last-responded line for the two edges following the response.
    assign w_discard = w_fifo_hit
                     || (((r_state != c_ST_IDLE) || (r_last_cnt != 2'd0))
                         && (r_svc_line == w_req_line));

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_respond   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (r_lat_cnt == 4'd1) begin
                    w_respond   = 1'b1;
                    w_state_nxt = c_ST_RESP;
                end
            end
            c_ST_RESP: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    assign w_accept  = mem_req && !w_discard && ((r_count < c_CNT_W'(QDEPTH)) || w_pop);
    assign w_drop    = mem_req && !w_discard && !((r_count < c_CNT_W'(QDEPTH)) || w_pop);
    // A same-edge write wins over the stored line.
    assign w_rd_data = (wb_valid && (w_wb_idx == w_rd_idx)) ? wb_wdata : r_store[w_rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_fifo_vld  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_svc_line  <= '0;
            r_lat_cnt   <= 4'd0;
            r_last_cnt  <= 2'd0;
            r_mem_valid <= 1'b0;
            r_mem_rdata <= '0;
            r_drop_cnt  <= 16'd0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_fifo_line[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            // Pop before push so a full-FIFO push into the freed slot keeps its valid bit.
            if (w_pop) begin
                r_fifo_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr             <= ptr_inc(r_rd_ptr);
                r_svc_line           <= r_fifo_line[r_rd_ptr];
                r_lat_cnt            <= (lat_cfg == 4'd0) ? 4'd1 : lat_cfg;
            end else if ((r_state == c_ST_WAIT) && !w_respond) begin
                r_lat_cnt <= r_lat_cnt - 4'd1;
            end
            if (w_accept) begin
                r_fifo_line[r_wr_ptr] <= w_req_line;
                r_fifo_vld[r_wr_ptr]  <= 1'b1;
                r_wr_ptr              <= ptr_inc(r_wr_ptr);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_mem_valid <= w_respond;
            if (w_respond) begin
                r_mem_rdata <= w_rd_data;
                r_last_cnt  <= 2'd2;
            end else if (r_last_cnt != 2'd0) begin
                r_last_cnt <= r_last_cnt - 2'd1;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wb_valid) begin
            r_store[w_wb_idx] <= wb_wdata;
        end
    end

    assign mem_valid    = r_mem_valid;
    assign mem_rdata    = r_mem_rdata;
    assign req_drop_cnt = r_drop_cnt;
    assign busy         = (r_count != '0) || (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_l3_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_l3_mem_responder
//  Purpose  : Self-checking bench: vector table, directed corner sequences and
//             random traffic against a queue-based transaction model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_l3_mem_responder;
    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    lat_cfg;
    logic          mem_req;
    logic [47:0]   mem_addr;
    logic [1023:0] mem_rdata;
    logic          mem_valid;
    logic          wb_valid;
    logic [47:0]   wb_addr;
    logic [1023:0] wb_wdata;
    logic [15:0]   req_drop_cnt;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    l3_mem_responder #(.LINES(256), .QDEPTH(4)) dut (
        .clk(clk), .rst(rst), .lat_cfg(lat_cfg),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
        .req_drop_cnt(req_drop_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // Transaction model: pending lines in a queue, the in-service request as
    // (pop edge, latency); its response edge is pop edge + latency.
    longint        t_now = 0;
    logic [40:0]   m_q [$];
    bit            m_svc_vld;
    longint        m_p;
    int            m_lat;
    logic [40:0]   m_svc_line;
    logic [1023:0] m_store [256];
    bit            m_known [256];
    logic          m_valid;
    logic [1023:0] m_rdata;
    bit            m_rd_known;
    int            m_drop;
    logic          m_busy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_line(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got low128 %h expected low128 %h (t=%0t)", name, act[127:0], exp[127:0], $time);
        end
    endtask

    function automatic logic [1023:0] rand_line();
        logic [1023:0] v;
        for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic model_edge();
        logic [40:0] rl;
        bit          dup, pop, in_svc;
        int          ridx, widx;
        t_now++;
        widx = int'(wb_addr[14:7]);
        if (rst) begin
            m_q.delete();
            m_svc_vld = 0; m_valid = 0; m_rdata = '0; m_rd_known = 1; m_drop = 0; m_busy = 0;
            if (wb_valid) begin m_store[widx] = wb_wdata; m_known[widx] = 1; end
            return;
        end
        rl     = mem_addr[47:7];
        in_svc = m_svc_vld && (t_now > m_p) && (t_now <= m_p + m_lat + 1);
        m_valid = 0;
        if (m_svc_vld && (t_now == m_p + m_lat)) begin
            m_valid = 1;
            ridx    = int'(m_svc_line[7:0]);
            if (wb_valid && widx == ridx) begin
                m_rdata = wb_wdata; m_rd_known = 1;
            end else begin
                m_rdata = m_store[ridx]; m_rd_known = m_known[ridx];
            end
        end
        dup = 0;
        foreach (m_q[i]) if (m_q[i] == rl) dup = 1;
        if (m_svc_vld && (t_now > m_p) && (t_now <= m_p + m_lat + 2) && (m_svc_line == rl)) dup = 1;
        pop = !in_svc && (m_q.size() > 0);
        if (mem_req && !dup) begin
            if (m_q.size() < 4 || pop) m_q.push_back(rl);
            else if (m_drop < 65535) m_drop++;
        end
        if (pop) begin
            m_svc_line = m_q.pop_front();
            m_svc_vld  = 1;
            m_p        = t_now;
            m_lat      = (lat_cfg == 0) ? 1 : int'(lat_cfg);
        end
        if (wb_valid) begin m_store[widx] = wb_wdata; m_known[widx] = 1; end
        m_busy = (m_q.size() > 0) || (m_svc_vld && (t_now <= m_p + m_lat));
    endtask

    // One clock: inputs were set while clk low; outputs checked 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_mem_valid", 64'(mem_valid), 64'(m_valid));
        chk("model_busy", 64'(busy), 64'(m_busy));
        chk("model_drop_cnt", 64'(req_drop_cnt), 64'(m_drop));
        if (m_rd_known) chk_line("model_mem_rdata", mem_rdata, m_rdata);
        @(negedge clk);
    endtask

    task automatic write_line(input logic [47:0] a, input logic [1023:0] d);
        wb_valid = 1; wb_addr = a; wb_wdata = d;
        step();
        wb_valid = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    typedef struct {
        logic [3:0]  lat;
        logic [47:0] addr;
        logic [7:0]  fill;
        int          exp_delay;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, pulses, n_resp;
        bit got;

        vecs[0] = '{4'd3,  48'h0000_0000_0080,  8'hA5, 4};
        vecs[1] = '{4'd0,  48'h0001_2345_6700,  8'h3C, 2};
        vecs[2] = '{4'd1,  48'h0000_0000_0100,  8'h11, 2};
        vecs[3] = '{4'd2,  48'hFFFF_FFFF_FF80,  8'h96, 3};
        vecs[4] = '{4'd7,  48'h0000_0000_4000,  8'h0F, 8};
        vecs[5] = '{4'd15, 48'h0000_0000_0180,  8'hE1, 16};

        for (int i = 0; i < 256; i++) m_known[i] = 0;
        rst = 1; lat_cfg = 4'd3; mem_req = 0; mem_addr = '0;
        wb_valid = 0; wb_addr = '0; wb_wdata = '0;
        idle(2);
        chk("reset_mem_valid", 64'(mem_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_drop_cnt", 64'(req_drop_cnt), 64'd0);
        chk_line("reset_mem_rdata", mem_rdata, '0);
        rst = 0;
        idle(2);

        // Latency / data table; request address low bits are deliberately non-zero.
        for (int v = 0; v < 6; v++) begin
            lat_cfg = vecs[v].lat;
            write_line(vecs[v].addr, {128{vecs[v].fill}});
            mem_req = 1; mem_addr = vecs[v].addr | 48'h5B;
            step();
            mem_req = 0;
            k = 0; got = 0;
            while (!got && k < 40) begin
                step(); k++;
                if (mem_valid) got = 1;
            end
            chk("tbl_latency", 64'(k), 64'(vecs[v].exp_delay));
            chk_line("tbl_rdata", mem_rdata, {128{vecs[v].fill}});
            step();
            chk("tbl_single_pulse", 64'(mem_valid), 64'd0);
            chk_line("tbl_rdata_hold", mem_rdata, {128{vecs[v].fill}});
            idle(3);
        end

        // Held request on one line yields one response.
        lat_cfg = 4'd3; mem_req = 1; mem_addr = 48'h80;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 6) mem_req = 0;
            step();
            if (mem_valid) pulses++;
        end
        chk("held_req_pulses", 64'(pulses), 64'd1);
        chk("held_req_drop", 64'(req_drop_cnt), 64'd0);

        // Burst of seven distinct lines at max latency: five served, two dropped.
        lat_cfg = 4'd15;
        for (int i = 0; i < 7; i++) write_line(48'((32'h20 + i) << 7), {128{8'(8'hC0 + i)}});
        for (int i = 0; i < 7; i++) begin
            mem_req = 1; mem_addr = 48'((32'h20 + i) << 7);
            step();
        end
        mem_req = 0;
        n_resp = 0;
        for (int c = 0; c < 200 && !(n_resp >= 5 && !busy); c++) begin
            step();
            if (mem_valid) begin
                chk("burst_order", 64'(mem_rdata[7:0]), 64'(8'hC0 + n_resp));
                n_resp++;
            end
        end
        chk("burst_count", 64'(n_resp), 64'd5);
        chk("burst_drop", 64'(req_drop_cnt), 64'd2);

        // Write to the line on the very edge its response is generated.
        lat_cfg = 4'd1;
        write_line(48'h2000, {128{8'h33}});
        mem_req = 1; mem_addr = 48'h2000;
        step();
        mem_req = 0;
        step();
        wb_valid = 1; wb_addr = 48'h2000; wb_wdata = {128{8'h5A}};
        step();
        wb_valid = 0;
        chk("wb_bypass_valid", 64'(mem_valid), 64'd1);
        chk_line("wb_bypass_rdata", mem_rdata, {128{8'h5A}});
        idle(4);

        // Reset while waiting aborts the request; the store survives.
        lat_cfg = 4'd10; mem_req = 1; mem_addr = 48'h80;
        step();
        mem_req = 0;
        idle(3);
        chk("pre_reset_busy", 64'(busy), 64'd1);
        rst = 1;
        #1;
        chk("async_reset_valid", 64'(mem_valid), 64'd0);
        chk("async_reset_busy", 64'(busy), 64'd0);
        chk("async_reset_drop", 64'(req_drop_cnt), 64'd0);
        @(negedge clk);
        idle(2);
        rst = 0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (mem_valid) pulses++;
        end
        chk("abort_no_valid", 64'(pulses), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        lat_cfg = 4'd2; mem_req = 1; mem_addr = 48'h80;
        step();
        mem_req = 0;
        k = 0; got = 0;
        while (!got && k < 40) begin
            step(); k++;
            if (mem_valid) got = 1;
        end
        chk("post_reset_latency", 64'(k), 64'd3);
        chk_line("post_reset_rdata", mem_rdata, {128{8'hA5}});
        idle(4);

        // Random traffic over a small aliased line pool.
        for (int i = 0; i < 8; i++) write_line(48'(i << 7), rand_line());
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 49) == 0) lat_cfg = 4'($urandom_range(0, 5));
            mem_req  = 1'($urandom_range(0, 1));
            mem_addr = '0;
            mem_addr[16:15] = 2'($urandom_range(0, 3));
            mem_addr[9:7]   = 3'($urandom_range(0, 7));
            mem_addr[6:0]   = 7'($urandom_range(0, 127));
            wb_valid = ($urandom_range(0, 3) == 0);
            wb_addr  = 48'($urandom_range(0, 7) << 7);
            wb_wdata = rand_line();
            step();
        end
        rst = 0; mem_req = 0; wb_valid = 0;
        idle(40);
        chk("final_idle_busy", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
